// File: rtl/proc_controller.sv
// proc_controller: Moore control FSM for the 16-bit processor datapath.
// It walks each instruction through Init/Fetch/Decode and an execute state,
// and drives every datapath control input. It holds no data of its own.
//
// Ports:
//   Clk         system clock, rising edge
//   Reset       synchronous active-high reset, forces Init
//   IR[15:0]    current instruction, opcode in IR[15:12]
//   PC_clr      clear program counter (Init)
//   PC_up       increment program counter (Fetch)
//   IR_ld       load instruction register (Fetch)
//   D_addr[7:0] data-RAM address
//   D_wr        data-RAM write enable
//   RF_s        RF write-data select: 0 = ALU result, 1 = RAM read data
//   RF_W_addr   RF write address
//   RF_W_en     RF write enable
//   RF_Ra_addr  RF read port A address
//   RF_Rb_addr  RF read port B address
//   ALU_s0[2:0] ALU function: 000 pass, 001 add, 010 sub
//   OutState    current state code for debug/display
module proc_controller (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] IR,
   output logic        PC_clr,
   output logic        PC_up,
   output logic        IR_ld,
   output logic [7:0]  D_addr,
   output logic        D_wr,
   output logic        RF_s,
   output logic [3:0]  RF_W_addr,
   output logic        RF_W_en,
   output logic [3:0]  RF_Ra_addr,
   output logic [3:0]  RF_Rb_addr,
   output logic [2:0]  ALU_s0,
   output logic [3:0]  OutState
);

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   typedef enum logic [3:0] {
      OP_NOOP  = 4'h0,
      OP_STORE = 4'h1,
      OP_LOAD  = 4'h2,
      OP_ADD   = 4'h3,
      OP_SUB   = 4'h4,
      OP_HALT  = 4'h5
   } opcode_t;

   state_t     state;
   state_t     next_state;
   logic [3:0] opcode;

   assign opcode = IR[15:12];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= S_INIT;
      end else begin
         state <= next_state;
      end
   end

   // Opcode is consulted only in Decode, so IR changes during execute
   // states move address fields but never the state sequence.
   always_comb begin
      next_state = S_INIT;
      case (state)
         S_INIT:   next_state = S_FETCH;
         S_FETCH:  next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_STORE: next_state = S_STORE;
               OP_LOAD:  next_state = S_LOAD_A;
               OP_ADD:   next_state = S_ADD;
               OP_SUB:   next_state = S_SUB;
               OP_HALT:  next_state = S_HALT;
               default:  next_state = S_NOOP;
            endcase
         end
         S_NOOP:   next_state = S_FETCH;
         S_LOAD_A: next_state = S_LOAD_B;
         S_LOAD_B: next_state = S_FETCH;
         S_STORE:  next_state = S_FETCH;
         S_ADD:    next_state = S_FETCH;
         S_SUB:    next_state = S_FETCH;
         S_HALT:   next_state = S_HALT;
         // Unused codes 10-15 recover through Init.
         default:  next_state = S_INIT;
      endcase
   end

   always_comb begin
      PC_clr     = 1'b0;
      PC_up      = 1'b0;
      IR_ld      = 1'b0;
      D_addr     = '0;
      D_wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_addr  = '0;
      RF_W_en    = 1'b0;
      RF_Ra_addr = '0;
      RF_Rb_addr = '0;
      ALU_s0     = '0;
      case (state)
         S_INIT: PC_clr = 1'b1;
         S_FETCH: begin
            IR_ld = 1'b1;
            PC_up = 1'b1;
         end
         // Decode sets up addresses one cycle early so the synchronous RAM
         // and RF reads are under way when the execute state begins.
         S_DECODE: begin
            case (opcode)
               OP_LOAD: D_addr = IR[11:4];
               OP_STORE: begin
                  D_addr     = IR[7:0];
                  RF_Ra_addr = IR[11:8];
               end
               OP_ADD, OP_SUB: begin
                  RF_Ra_addr = IR[11:8];
                  RF_Rb_addr = IR[7:4];
               end
               default: ;
            endcase
         end
         S_LOAD_A, S_LOAD_B: begin
            D_addr    = IR[11:4];
            RF_s      = 1'b1;
            RF_W_addr = IR[3:0];
            // Load_A absorbs the RAM read latency; write only in Load_B.
            RF_W_en   = (state == S_LOAD_B);
         end
         S_STORE: begin
            D_addr     = IR[7:0];
            RF_Ra_addr = IR[11:8];
            D_wr       = 1'b1;
         end
         S_ADD, S_SUB: begin
            RF_Ra_addr = IR[11:8];
            RF_Rb_addr = IR[7:4];
            RF_W_addr  = IR[3:0];
            RF_W_en    = 1'b1;
            ALU_s0     = (state == S_ADD) ? 3'b001 : 3'b010;
         end
         default: ;
      endcase
   end

   assign OutState = state;

endmodule

// File: doc/proc_controller.md
Name: proc_controller

Overview:
- Moore-style control FSM for the 16-bit processor datapath.
- Sequences each instruction through fetch, decode and execute by driving:
  - PC clear/increment and the IR load strobe
  - data-RAM address and write enable
  - register-file read/write addresses and write enable
  - the register-file write-data 2-to-1 mux select (RAM data vs ALU result)
  - the ALU function select
- Sits between the IR and all datapath control inputs. Holds no data itself.

Parameters:
- None. Instruction format is fixed at 16 bits: opcode IR[15:12].

Ports:
- Clk  input  1  system clock; all state changes on rising edge
- Reset  input  1  synchronous, active-high; forces state Init
- IR  input  16  current instruction from instruction register
- PC_clr  output  1  clear program counter
- PC_up  output  1  increment program counter
- IR_ld  output  1  load instruction register from instruction ROM
- D_addr  output  8  data-RAM address
- D_wr  output  1  data-RAM write enable
- RF_s  output  1  RF write-data mux select: 0 = ALU result, 1 = RAM read data
- RF_W_addr  output  4  RF write address
- RF_W_en  output  1  RF write enable
- RF_Ra_addr  output  4  RF read port A address
- RF_Rb_addr  output  4  RF read port B address
- ALU_s0  output  3  ALU function: 000 pass/zero, 001 add, 010 sub
- OutState  output  4  current state code, for debug and display

Behaviour:
- One clock; reset is synchronous and active-high.
- State encoding (OutState):
  - Init=0, Fetch=1, Decode=2, NOOP=3, Load_A=4, Load_B=5, Store=6, Add=7, Sub=8, Halt=9.
  - Codes 10-15 are unreachable; if entered, next state is Init.
- Opcodes: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT. Opcodes 0110-1111 decode as NOOP.
- Field slicing:
  - LOAD: D_addr=IR[11:4], Rd=IR[3:0]
  - STORE: Ra=IR[11:8], D_addr=IR[7:0]
  - ADD/SUB: Ra=IR[11:8], Rb=IR[7:4], Rd=IR[3:0]
- Outputs are combinational from the current state (and IR fields). Every output not listed for a state is 0.
- Init: PC_clr=1. Always goes to Fetch next cycle.
- Fetch: IR_ld=1, PC_up=1. Goes to Decode. IR is valid from the Decode cycle onward.
- Decode: pre-drives addresses for the upcoming operation; no write enables asserted.
  - LOAD: D_addr=IR[11:4]
  - STORE: D_addr=IR[7:0], RF_Ra_addr=IR[11:8]
  - ADD/SUB: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4]
  - Next state chosen by opcode.
- NOOP: all outputs 0. Goes to Fetch.
- Load_A: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0], RF_W_en=0. Covers the synchronous RAM read latency. Goes to Load_B.
- Load_B: same outputs as Load_A but RF_W_en=1. Goes to Fetch.
- Store: D_addr=IR[7:0], RF_Ra_addr=IR[11:8], D_wr=1. Goes to Fetch.
- Add: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_s=0, ALU_s0=001, RF_W_en=1. Goes to Fetch.
- Sub: same as Add but ALU_s0=010.
- Halt: all outputs 0. Self-loops until Reset.
- Instruction latency, counted from Fetch to the next Fetch:
  - NOOP/STORE/ADD/SUB: 3 cycles
  - LOAD: 4 cycles
  - HALT: never returns to Fetch
- Reset dominates every state, including mid-Load (Load_A/Load_B) and Halt.
  - Next edge enters Init; no D_wr or RF_W_en is asserted in the cycle after the reset edge.
- IR changing outside the Fetch→Decode boundary does not alter the next-state choice; it only affects combinational address fields.
- Reset values: state=Init. Hence PC_clr=1, OutState=0, all other outputs 0.
- Exactly one of {D_wr, RF_W_en} may be high in any cycle. IR_ld is high only in Fetch.

Test Plan:
- Reset held 2 cycles, then released → OutState sequence 0,1,2. PC_clr=1 only in Init; IR_ld=PC_up=1 only in Fetch.
- IR=16'h2A45 (LOAD [0xA4]→R5) → Decode D_addr=0xA4. Load_A: RF_s=1, RF_W_en=0, RF_W_addr=5. Load_B: RF_W_en=1. Then Fetch; 4-cycle loop.
- IR=16'h3128 (ADD R1+R2→R8) → Add state: Ra=1, Rb=2, W_addr=8, ALU_s0=001, RF_s=0, RF_W_en=1. IR=16'h4128 gives the same with ALU_s0=010.
- IR=16'h1B3C (STORE R11→[0x3C]) → Store state: D_addr=0x3C, RF_Ra_addr=11, D_wr=1, RF_W_en=0.
- IR=16'h5000 → Halt (OutState=9) for ≥10 cycles, all outputs 0. Reset → Init. IR=16'hF123 → NOOP (OutState=3).
- Reset asserted during Load_A → next state Init. Load_B never entered; RF_W_en stays 0.
